// File: rtl/i2c_cmd_arbiter.sv
// ============================================================================
//  Module   : i2c_cmd_arbiter
//  Purpose  : Round-robin arbiter that shares one IIC master between several
//             CODEC command sources. Grants one requester at a time, drives a
//             single IIC transfer, detects completion on a rising FINISHED
//             edge, returns a per-requester ACK and enforces an idle gap.
//  Options  : ARB_TIMEOUT_EN - when defined, a hung transfer is aborted after
//             TIMEOUT_CYCLES in WAIT and flagged with ERR alongside ACK.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_cmd_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   MCLK,
    input  logic                   RESET,
    input  logic [NUM_REQ-1:0]     REQ,
    input  logic [16*NUM_REQ-1:0]  REQ_DATA,
    output logic [NUM_REQ-1:0]     GNT,
    output logic [NUM_REQ-1:0]     ACK,
    output logic                   ERR,
    output logic                   BUSY,
    output logic                   IIC_EN,
    output logic [15:0]            IIC_DATA,
    input  logic                   IIC_FINISHED
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] c_ONE      = NUM_REQ'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    logic [1:0]           r_state, w_state_nxt;
    logic [c_IDX_W-1:0]   r_last,  w_last_nxt;
    logic [c_IDX_W-1:0]   r_sel,   w_sel_nxt;
    logic [15:0]          r_data,  w_data_nxt;
    logic                 r_en,    w_en_nxt;
    logic [NUM_REQ-1:0]   r_gnt,   w_gnt_nxt;
    logic [NUM_REQ-1:0]   r_ack,   w_ack_nxt;
    logic [c_GAP_W-1:0]   r_gap,   w_gap_nxt;
    logic                 r_fin_q;
    logic                 w_fin_rise;

    logic [c_IDX_W-1:0]   w_pick;
    logic [15:0]          w_slice;
    logic                 w_hi_found;
    logic [c_IDX_W-1:0]   w_hi_idx;
    logic [c_IDX_W-1:0]   w_lo_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    logic [c_TO_W-1:0]    r_to,  w_to_nxt;
    logic                 r_err, w_err_nxt;
`else
    // Timeout support is compiled out; the parameter is intentionally unused.
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
`endif

    assign w_fin_rise = IIC_FINISHED & ~r_fin_q;

    assign GNT      = r_gnt;
    assign ACK      = r_ack;
    assign BUSY     = (r_state != c_ST_IDLE);
    assign IIC_EN   = r_en;
    assign IIC_DATA = r_data;
`ifdef ARB_TIMEOUT_EN
    assign ERR      = r_err;
`else
    assign ERR      = 1'b0;
`endif

    // Round-robin pick: lowest requesting index above last, else lowest overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (REQ[i]) begin
                w_lo_idx = c_IDX_W'(i);
                if (i > int'(r_last)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = c_IDX_W'(i);
                end
            end
        end
        w_pick  = w_hi_found ? w_hi_idx : w_lo_idx;
        w_slice = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(w_pick)) begin
                w_slice = REQ_DATA[16*i +: 16];
            end
        end
    end

    // Next-state and output decode for the IDLE / WAIT / GAP sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_sel_nxt   = r_sel;
        w_data_nxt  = r_data;
        w_en_nxt    = r_en;
        w_gnt_nxt   = '0;
        w_ack_nxt   = '0;
        w_gap_nxt   = r_gap;
`ifdef ARB_TIMEOUT_EN
        w_to_nxt    = r_to;
        w_err_nxt   = 1'b0;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (|REQ) begin
                    w_sel_nxt   = w_pick;
                    w_last_nxt  = w_pick;
                    w_data_nxt  = w_slice;
                    w_gnt_nxt   = c_ONE << w_pick;
                    w_en_nxt    = 1'b1;
                    w_state_nxt = c_ST_WAIT;
`ifdef ARB_TIMEOUT_EN
                    w_to_nxt    = '0;
`endif
                end
            end
            c_ST_WAIT: begin
                // Completion takes priority over a coincident timeout.
                if (w_fin_rise) begin
                    w_en_nxt    = 1'b0;
                    w_ack_nxt   = c_ONE << r_sel;
                    w_gap_nxt   = '0;
                    w_state_nxt = c_ST_GAP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_to == c_TO_LAST) begin
                    w_en_nxt    = 1'b0;
                    w_ack_nxt   = c_ONE << r_sel;
                    w_err_nxt   = 1'b1;
                    w_gap_nxt   = '0;
                    w_state_nxt = c_ST_GAP;
                end else begin
                    w_to_nxt    = r_to + 1'b1;
                end
`endif
            end
            c_ST_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_gap_nxt   = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_en_nxt    = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer without ACK.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
            r_last  <= c_LAST_RST;
            r_sel   <= '0;
            r_data  <= 16'h0000;
            r_en    <= 1'b0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_gap   <= '0;
            r_fin_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_to    <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_sel   <= w_sel_nxt;
            r_data  <= w_data_nxt;
            r_en    <= w_en_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_gap   <= w_gap_nxt;
            r_fin_q <= IIC_FINISHED;
`ifdef ARB_TIMEOUT_EN
            r_to    <= w_to_nxt;
            r_err   <= w_err_nxt;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_cmd_arbiter.sv
// ============================================================================
//  Module   : tb_i2c_cmd_arbiter
//  Purpose  : Directed self-checking bench for i2c_cmd_arbiter (2 requesters,
//             4-cycle gap, 100-cycle timeout when ARB_TIMEOUT_EN is defined).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_cmd_arbiter;

    localparam int NUM_REQ        = 2;
    localparam int GAP_CYCLES     = 4;
    localparam int TIMEOUT_CYCLES = 100;

    logic         MCLK         = 1'b0;
    logic         RESET        = 1'b1;
    logic [1:0]   REQ          = '0;
    logic [31:0]  REQ_DATA     = '0;
    logic         IIC_FINISHED = 1'b0;
    logic [1:0]   GNT;
    logic [1:0]   ACK;
    logic         ERR;
    logic         BUSY;
    logic         IIC_EN;
    logic [15:0]  IIC_DATA;

    int n_checks = 0;
    int n_pass   = 0;

    i2c_cmd_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_dut (
        .MCLK         (MCLK),
        .RESET        (RESET),
        .REQ          (REQ),
        .REQ_DATA     (REQ_DATA),
        .GNT          (GNT),
        .ACK          (ACK),
        .ERR          (ERR),
        .BUSY         (BUSY),
        .IIC_EN       (IIC_EN),
        .IIC_DATA     (IIC_DATA),
        .IIC_FINISHED (IIC_FINISHED)
    );

    always #10 MCLK = ~MCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge MCLK);
        #1;
    endtask

    // One complete transfer starting from IDLE with REQ already presented.
    task automatic xfer(input string tag, input logic [1:0] exp_g, input logic [15:0] exp_d,
                        input int hold, input bit drop);
        tick;
        check({tag, "_gnt"},  32'(GNT), 32'(exp_g));
        check({tag, "_en"},   32'(IIC_EN), 32'd1);
        check({tag, "_data"}, 32'(IIC_DATA), 32'(exp_d));
        check({tag, "_busy"}, 32'(BUSY), 32'd1);
        tick;
        check({tag, "_gnt_pulse"}, 32'(GNT), 32'd0);
        repeat (hold) tick;
        check({tag, "_wait_en"},  32'(IIC_EN), 32'd1);
        check({tag, "_wait_ack"}, 32'(ACK), 32'd0);
        IIC_FINISHED = 1'b1;
        tick;
        check({tag, "_ack"},    32'(ACK), 32'(exp_g));
        check({tag, "_ack_en"}, 32'(IIC_EN), 32'd0);
        check({tag, "_err"},    32'(ERR), 32'd0);
        IIC_FINISHED = 1'b0;
        if (drop) REQ = '0;
        for (int i = 0; i < GAP_CYCLES - 1; i++) begin
            tick;
            check({tag, "_gap_busy"}, 32'(BUSY), 32'd1);
            check({tag, "_gap_en"},   32'(IIC_EN), 32'd0);
            check({tag, "_gap_ack"},  32'(ACK), 32'd0);
        end
        tick;
        check({tag, "_idle"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_ack;
        bit saw_err;

        // Reset values.
        tick;
        tick;
        check("rst_en",   32'(IIC_EN), 32'd0);
        check("rst_data", 32'(IIC_DATA), 32'h0);
        check("rst_gnt",  32'(GNT), 32'd0);
        check("rst_ack",  32'(ACK), 32'd0);
        check("rst_err",  32'(ERR), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        RESET = 1'b0;
        tick;
        check("idle_busy", 32'(BUSY), 32'd0);

        // Single transfer, FINISHED 200 cycles after IIC_EN rises.
        REQ      = 2'b01;
        REQ_DATA = {16'h0000, 16'h0017};
        xfer("single", 2'b01, 16'h0017, 198, 1'b1);
        tick;
        check("single_no_regrant", 32'(GNT), 32'd0);
        check("single_stay_idle",  32'(BUSY), 32'd0);

        // Continuous requests from both sources rotate fairly.
        RESET = 1'b1;
        tick;
        RESET    = 1'b0;
        REQ      = 2'b11;
        REQ_DATA = {16'h0A01, 16'h0479};
        xfer("rr0", 2'b01, 16'h0479, 10, 1'b0);
        xfer("rr1", 2'b10, 16'h0A01, 10, 1'b0);
        xfer("rr2", 2'b01, 16'h0479, 10, 1'b0);
        xfer("rr3", 2'b10, 16'h0A01, 10, 1'b1);

        // FINISHED already high at grant is not a completion.
        IIC_FINISHED = 1'b1;
        tick;
        REQ      = 2'b01;
        REQ_DATA = {16'h0000, 16'h1234};
        tick;
        check("fin_hi_gnt", 32'(GNT), 32'd1);
        repeat (20) tick;
        check("fin_hi_busy", 32'(BUSY), 32'd1);
        check("fin_hi_ack",  32'(ACK), 32'd0);
        check("fin_hi_en",   32'(IIC_EN), 32'd1);
        IIC_FINISHED = 1'b0;
        tick;
        check("fin_low_ack", 32'(ACK), 32'd0);
        IIC_FINISHED = 1'b1;
        tick;
        check("fin_edge_ack", 32'(ACK), 32'd1);
        IIC_FINISHED = 1'b0;
        REQ          = '0;
        repeat (GAP_CYCLES) tick;
        check("fin_edge_idle", 32'(BUSY), 32'd0);

        // Latched word survives REQ_DATA changes after grant.
        REQ      = 2'b01;
        REQ_DATA = {16'h0000, 16'h0E53};
        tick;
        check("latch_gnt",  32'(GNT), 32'd1);
        check("latch_data", 32'(IIC_DATA), 32'h0E53);
        REQ_DATA = {16'h0000, 16'hFFFF};
        repeat (30) tick;
        check("latch_hold", 32'(IIC_DATA), 32'h0E53);
        IIC_FINISHED = 1'b1;
        tick;
        check("latch_ack",      32'(ACK), 32'd1);
        check("latch_ack_data", 32'(IIC_DATA), 32'h0E53);
        IIC_FINISHED = 1'b0;
        REQ          = '0;
        repeat (GAP_CYCLES) tick;

        // Reset mid-transfer: no ACK, pointer returns to requester 0 first.
        REQ      = 2'b01;
        REQ_DATA = {16'h0A01, 16'h0479};
        tick;
        check("midrst_gnt", 32'(GNT), 32'd1);
        repeat (50) tick;
        RESET = 1'b1;
        REQ   = '0;
        tick;
        check("midrst_en",   32'(IIC_EN), 32'd0);
        check("midrst_busy", 32'(BUSY), 32'd0);
        check("midrst_ack",  32'(ACK), 32'd0);
        RESET = 1'b0;
        tick;
        check("midrst_ack2", 32'(ACK), 32'd0);
        REQ = 2'b11;
        xfer("postrst", 2'b01, 16'h0479, 5, 1'b1);

        // Hung transfer: FINISHED never rises.
        REQ = 2'b10;
        tick;
        check("hang_gnt", 32'(GNT), 32'd2);
        saw_ack = 1'b0;
        saw_err = 1'b0;
`ifdef ARB_TIMEOUT_EN
        repeat (TIMEOUT_CYCLES - 1) begin
            tick;
            saw_ack |= |ACK;
        end
        check("to_early_ack", 32'(saw_ack), 32'd0);
        tick;
        check("to_ack", 32'(ACK), 32'd2);
        check("to_err", 32'(ERR), 32'd1);
        check("to_en",  32'(IIC_EN), 32'd0);
        REQ = '0;
`else
        repeat (10000) begin
            tick;
            saw_ack |= |ACK;
            saw_err |= ERR;
        end
        check("hang_no_ack", 32'(saw_ack), 32'd0);
        check("hang_no_err", 32'(saw_err), 32'd0);
        check("hang_en",     32'(IIC_EN), 32'd1);
        IIC_FINISHED = 1'b1;
        tick;
        check("hang_late_ack", 32'(ACK), 32'd2);
        check("hang_late_err", 32'(ERR), 32'd0);
        IIC_FINISHED = 1'b0;
        REQ          = '0;
`endif
        repeat (GAP_CYCLES) tick;
        check("final_idle", 32'(BUSY), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
- Shares the single IIC master (ENABLE / Data[15:0] / FINISHED) between several command sources. Typical sources: the CODEC boot-configuration sequencer and a runtime volume/mute controller.
- Each requester presents one 16-bit CODEC word ({reg addr[6:0], value[8:0]}).
- The block grants requesters round-robin, drives exactly one IIC transfer at a time, detects completion and returns a per-requester ACK.
- It enforces an idle gap between transfers and can optionally abort a hung transfer.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..4).
- GAP_CYCLES, 4, MCLK cycles IIC_EN stays low between transfers (legal >= 2).
- TIMEOUT_CYCLES, 1000000, max MCLK cycles in WAIT before abort (used only with ARB_TIMEOUT_EN).

Ports:
- MCLK  in  1  system clock (50 MHz).
- RESET  in  1  reset. Synchronous, active-high, one clock.
- REQ  in  NUM_REQ  per-requester request level. Held high until that requester's ACK.
- REQ_DATA  in  16*NUM_REQ  command words. Requester i uses bits [16i+15:16i].
- GNT  out  NUM_REQ  one-cycle one-hot pulse when requester i's word is latched.
- ACK  out  NUM_REQ  one-cycle one-hot pulse when requester i's transfer ends.
- ERR  out  1  one-cycle pulse coincident with ACK when the transfer timed out.
- BUSY  out  1  high whenever state != IDLE.
- IIC_EN  out  1  to IIC ENABLE. Level, high for the duration of one transfer.
- IIC_DATA  out  16  to IIC Data. Stable while IIC_EN is high.
- IIC_FINISHED  in  1  from IIC FINISHED. A rising edge marks transfer completion.

Behaviour:
- Reset values:
  - State IDLE, IIC_EN=0, IIC_DATA=16'h0000.
  - GNT=0, ACK=0, ERR=0, BUSY=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
  - fin_q=0; gap and timeout counters = 0.
- fin_q registers IIC_FINISHED every cycle. fin_rise = IIC_FINISHED & ~fin_q.
- IDLE, any REQ high at edge t:
  - Select the first requesting index after last, wrapping.
  - Latch its slice into IIC_DATA and store the index in sel.
  - Set last=sel, GNT[sel]=1 for one cycle, IIC_EN=1, state WAIT.
  - IIC_EN therefore rises one cycle after REQ is sampled.
- IDLE, no REQ: hold.
- WAIT:
  - IIC_DATA and IIC_EN hold.
  - On fin_rise: IIC_EN=0, ACK[sel]=1 for one cycle, gap counter=0, state GAP.
  - FINISHED already high on WAIT entry is not a completion; only a new rising edge counts.
- GAP:
  - Count GAP_CYCLES cycles with IIC_EN=0, then go to IDLE. REQ is ignored during GAP.
  - A requester that drops REQ the cycle after its ACK is never re-granted. If REQ is still high when IDLE is re-entered, that is a new transfer.
- Fairness:
  - Under continuous requests from all sources, grants rotate 0,1,...,NUM_REQ-1,0...
  - A requester never waits more than NUM_REQ-1 foreign transfers.
- REQ_DATA may change after GNT; the latched copy is used.
- REQ dropped by its requester during WAIT: the transfer still completes and ACK is still pulsed.
- Simultaneous fin_rise and timeout expiry: completion wins, ERR=0.
- RESET mid-transfer: IIC_EN drops on the next edge, state IDLE, no ACK issued. The IIC core has its own reset.
- At most one bit of GNT and one bit of ACK is high in any cycle.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT, cleared on WAIT entry.
  - On reaching TIMEOUT_CYCLES without fin_rise: IIC_EN=0, ACK[sel]=1 and ERR=1 for one cycle, then GAP as normal.
- ARB_TIMEOUT_EN undefined:
  - No counter is built; WAIT persists until fin_rise.
  - ERR is tied 0. TIMEOUT_CYCLES is ignored.

Test Plan:
- Reset, then REQ=2'b01 with slice0=16'h0017, FINISHED pulsed 200 cycles after IIC_EN rises.
  - Expect GNT=01 one cycle and IIC_EN high the cycle after REQ, with IIC_DATA=0017.
  - Expect ACK=01 one cycle after the FINISHED edge, IIC_EN low 4 cycles, then BUSY=0.
- REQ=2'b11 held continuously (slice0=16'h0479, slice1=16'h0A01), each transfer completed.
  - Expect IIC_DATA sequence 0479, 0A01, 0479, 0A01 and GNT alternating 01,10,01,10.
- Hold IIC_FINISHED high before the grant, with no new edge.
  - Expect the block to stay in WAIT.
  - Drop FINISHED, raise it again: expect ACK one cycle later.
- Assert RESET 50 cycles into WAIT.
  - Expect IIC_EN=0, BUSY=0, no ACK next cycle.
  - Requester 0 (REQ=01) then wins the next grant.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, FINISHED never rises.
  - Expect ACK[sel]=1 and ERR=1 together, 100 cycles after WAIT entry.
  - Without the macro: expect no ACK after 10000 cycles and ERR stuck at 0.
- Change REQ_DATA slice0 from 16'h0E53 to 16'hFFFF one cycle after GNT.
  - Expect IIC_DATA to remain 0E53 until ACK.
